pad_mux_ctrl: RTL and testbench

Parametrised pad-multiplexing controller between the chip pad ring and the SoC peripherals. It routes one of `N_FUNC` alternate functions onto each of `N_PADS` bidirectional pads and synchronises pad inputs back to the selected function. Reconfiguration is glitch-free: a pad whose function changes is tristated for a guard interval and its input is gated while the synchroniser refills. It generalises the fixed GPIO/pad-config scheme of the current top level to arbitrary pad and function counts.

---
 rtl/pad_mux_pkg.sv | 23 ++
 rtl/pad_mux_ctrl_sync.sv | 23 ++
 rtl/pad_mux_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pad_mux_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_mux_pkg.sv
// rtl/pad_mux_pkg.sv - FSM states, safe-state constants and sizing helpers for the pad multiplexer
package pad_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY,
        ST_SETTLE
    } pm_state_e;

    localparam logic SAFE_OUT = 1'b0;
    localparam logic SAFE_OEN = 1'b1;
    localparam logic SAFE_IE  = 1'b0;

    function automatic int fsel_w(input int n_func);
        return (n_func > 1) ? $clog2(n_func) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pad_mux_ctrl_sync.sv
// rtl/pad_mux_ctrl_sync.sv - reset-to-0 flop chain synchronising one raw pad input
module pad_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pad_mux_ctrl.sv
// rtl/pad_mux_ctrl.sv - per-pad function mux with glitch-free tristate/settle on reconfiguration
module pad_mux_ctrl
    import pad_mux_pkg::*;
#(
    parameter int N_PADS       = 32,
    parameter int N_FUNC       = 4,
    parameter int CFG_W        = 6,
    parameter int GUARD_CYCLES = 4,
    parameter int SYNC_STAGES  = 2,
    localparam int FSEL_W      = fsel_w(N_FUNC)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [N_PADS*FSEL_W-1:0]   mux_sel_i,
    input  logic [N_PADS*CFG_W-1:0]    cfg_i,
    input  logic [N_FUNC*N_PADS-1:0]   func_out_i,
    input  logic [N_FUNC*N_PADS-1:0]   func_oen_i,
    output logic [N_FUNC*N_PADS-1:0]   func_in_o,
    input  logic [N_PADS-1:0]          pad_in_i,
    output logic [N_PADS-1:0]          pad_out_o,
    output logic [N_PADS-1:0]          pad_oen_o,
    output logic [N_PADS-1:0]          pad_ie_o,
    output logic [N_PADS*CFG_W-1:0]    pad_cfg_o,
    output logic                       busy_o
);

    localparam int CNT_W = $clog2(max_int(GUARD_CYCLES, SYNC_STAGES) + 1);

    pm_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [N_PADS*FSEL_W-1:0]  sel_q, sel_d, req_sel_q, req_sel_d;
    logic [N_PADS*CFG_W-1:0]   cfg_q, cfg_d, req_cfg_q, req_cfg_d;
    logic [N_PADS-1:0]         mask_q, mask_d, new_mask;
    logic [N_PADS-1:0]         out_q, out_d, oen_q, oen_d, ie_q, ie_d;
    logic [N_PADS-1:0]         sync_q;

    always_comb begin
        new_mask = '0;
        for (int p = 0; p < N_PADS; p++) begin
            new_mask[p] = (mux_sel_i[p*FSEL_W +: FSEL_W] != sel_q[p*FSEL_W +: FSEL_W]);
        end
    end

    // sel/cfg are loaded on the edge entering APPLY so the pads show them during APPLY
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        cfg_d     = cfg_q;
        req_sel_d = req_sel_q;
        req_cfg_d = req_cfg_q;
        mask_d    = mask_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid_i) begin
                    req_sel_d = mux_sel_i;
                    req_cfg_d = cfg_i;
                    mask_d    = new_mask;
                    cnt_d     = '0;
                    if (|new_mask) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_APPLY;
                        sel_d   = mux_sel_i;
                        cfg_d   = cfg_i;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
                    state_d = ST_APPLY;
                    sel_d   = req_sel_q;
                    cfg_d   = req_cfg_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_APPLY: begin
                if (|mask_q) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SYNC_STAGES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // pad registers look at next-cycle state/sel so they line up with the FSM cycle
    always_comb begin
        out_d = '0;
        oen_d = '0;
        ie_d  = '0;
        for (int p = 0; p < N_PADS; p++) begin
            if (mask_d[p] && state_d == ST_DRAIN) begin
                out_d[p] = SAFE_OUT;
                oen_d[p] = SAFE_OEN;
                ie_d[p]  = SAFE_IE;
            end else if (int'(sel_d[p*FSEL_W +: FSEL_W]) < N_FUNC) begin
                out_d[p] = func_out_i[int'(sel_d[p*FSEL_W +: FSEL_W])*N_PADS + p];
                oen_d[p] = func_oen_i[int'(sel_d[p*FSEL_W +: FSEL_W])*N_PADS + p];
                ie_d[p]  = 1'b1;
            end else begin
                out_d[p] = SAFE_OUT;
                oen_d[p] = SAFE_OEN;
                ie_d[p]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            cfg_q     <= '0;
            req_sel_q <= '0;
            req_cfg_q <= '0;
            mask_q    <= '0;
            out_q     <= '0;
            oen_q     <= '1;
            ie_q      <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            cfg_q     <= cfg_d;
            req_sel_q <= req_sel_d;
            req_cfg_q <= req_cfg_d;
            mask_q    <= mask_d;
            out_q     <= out_d;
            oen_q     <= oen_d;
            ie_q      <= ie_d;
        end
    end

    for (genvar p = 0; p < N_PADS; p++) begin : g_sync
        pad_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (pad_in_i[p]),
            .q     (sync_q[p])
        );
    end

    // a changed pad's input stays gated until its synchroniser has refilled
    always_comb begin
        func_in_o = '0;
        for (int f = 0; f < N_FUNC; f++) begin
            for (int p = 0; p < N_PADS; p++) begin
                if (int'(sel_q[p*FSEL_W +: FSEL_W]) == f && !(mask_q[p] && state_q != ST_IDLE)) begin
                    func_in_o[f*N_PADS + p] = sync_q[p];
                end
            end
        end
    end

    assign cfg_ready_o = (state_q == ST_IDLE);
    assign busy_o      = !cfg_ready_o;
    assign pad_out_o   = out_q;
    assign pad_oen_o   = oen_q;
    assign pad_ie_o    = ie_q;
    assign pad_cfg_o   = cfg_q;

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// tb/tb_pad_mux_ctrl.sv - scoreboard bench for pad_mux_ctrl against a transaction-timeline model
module tb_pad_mux_ctrl;

    localparam int N  = 32;
    localparam int F  = 4;
    localparam int CW = 6;
    localparam int G  = 4;
    localparam int S  = 2;
    localparam int SW = 2;

    typedef struct {
        logic [N-1:0]    out;
        logic [N-1:0]    oen;
        logic [N-1:0]    ie;
        logic [N*CW-1:0] cfg;
        logic [F*N-1:0]  fin;
        logic            ready;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [N*SW-1:0] mux_sel;
    logic [N*CW-1:0] cfg_in;
    logic [F*N-1:0]  func_out;
    logic [F*N-1:0]  func_oen;
    logic [F*N-1:0]  func_in;
    logic [N-1:0]    pad_in;
    logic [N-1:0]    pad_out;
    logic [N-1:0]    pad_oen;
    logic [N-1:0]    pad_ie;
    logic [N*CW-1:0] pad_cfg;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    exp_t exp_q[$];

    int           m_sel[N];
    int           m_cfg[N];
    int           r_sel[N];
    int           r_cfg[N];
    int           t_sel[N];
    int           t_cfg[N];
    bit           msk[N];
    bit           active;
    bit           changed;
    int           k;
    logic [N-1:0] hist[S];
    bit           ovr;
    logic         tog;

    pad_mux_ctrl #(
        .N_PADS(N), .N_FUNC(F), .CFG_W(CW), .GUARD_CYCLES(G), .SYNC_STAGES(S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .mux_sel_i   (mux_sel),
        .cfg_i       (cfg_in),
        .func_out_i  (func_out),
        .func_oen_i  (func_oen),
        .func_in_o   (func_in),
        .pad_in_i    (pad_in),
        .pad_out_o   (pad_out),
        .pad_oen_o   (pad_oen),
        .pad_ie_o    (pad_ie),
        .pad_cfg_o   (pad_cfg),
        .busy_o      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        active  = 1'b0;
        changed = 1'b0;
        k       = 0;
        for (int p = 0; p < N; p++) begin
            m_sel[p] = 0;
            m_cfg[p] = 0;
            msk[p]   = 1'b0;
        end
        for (int i = 0; i < S; i++) hist[i] = '0;
    endtask

    // cycle k counts from 1 = first cycle after the accepting edge
    task automatic model_edge();
        exp_t e;
        bit   acc;
        bit   safe;
        bit   gated;
        acc = cfg_valid && !active;
        for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pad_in;
        if (active) k++;
        if (acc) begin
            active  = 1'b1;
            k       = 1;
            changed = 1'b0;
            for (int p = 0; p < N; p++) begin
                r_sel[p] = int'(mux_sel[p*SW +: SW]);
                r_cfg[p] = int'(cfg_in[p*CW +: CW]);
                msk[p]   = (r_sel[p] != m_sel[p]);
                if (msk[p]) changed = 1'b1;
            end
        end
        if (active && ((changed && k == G + 1) || (!changed && k == 1))) begin
            m_sel = r_sel;
            m_cfg = r_cfg;
        end
        if (active && ((changed && k == G + S + 1) || (!changed && k == 2))) active = 1'b0;
        e.out = '0; e.oen = '0; e.ie = '0; e.cfg = '0; e.fin = '0;
        for (int p = 0; p < N; p++) begin
            safe  = active && changed && msk[p] && (k <= G);
            gated = active && changed && msk[p];
            e.out[p] = safe ? 1'b0 : func_out[m_sel[p]*N + p];
            e.oen[p] = safe ? 1'b1 : func_oen[m_sel[p]*N + p];
            e.ie[p]  = safe ? 1'b0 : 1'b1;
            e.cfg[p*CW +: CW] = CW'(m_cfg[p]);
            for (int f = 0; f < F; f++) begin
                e.fin[f*N + p] = (m_sel[p] == f && !gated) ? hist[S-1][p] : 1'b0;
            end
        end
        e.ready = !active;
        exp_q.push_back(e);
    endtask

    task automatic randomize_bg();
        func_out = {$urandom, $urandom, $urandom, $urandom};
        func_oen = {$urandom, $urandom, $urandom, $urandom};
        pad_in   = $urandom;
        if (ovr) begin
            func_out[2*N + 3] = 1'b1;
            func_oen[2*N + 3] = 1'b0;
            func_out[5]       = tog;
            func_oen[5]       = 1'b0;
            tog               = ~tog;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
        randomize_bg();
    endtask

    task automatic load_from_model();
        t_sel = m_sel;
        t_cfg = m_cfg;
    endtask

    task automatic drive_req();
        for (int p = 0; p < N; p++) begin
            mux_sel[p*SW +: SW] = SW'(t_sel[p]);
            cfg_in[p*CW +: CW]  = CW'(t_cfg[p]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("rst_ready",   {255'd0, cfg_ready}, 256'd1);
        chk("rst_busy",    {255'd0, busy},      256'd0);
        chk("rst_pad_out", 256'(pad_out),       256'd0);
        chk("rst_pad_oen", 256'(pad_oen),       256'(32'hFFFF_FFFF));
        chk("rst_pad_ie",  256'(pad_ie),        256'(32'hFFFF_FFFF));
        chk("rst_pad_cfg", 256'(pad_cfg),       256'd0);
        chk("rst_func_in", 256'(func_in),       256'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pad_out", 256'(pad_out), 256'(e.out));
                chk("pad_oen", 256'(pad_oen), 256'(e.oen));
                chk("pad_ie",  256'(pad_ie),  256'(e.ie));
                chk("pad_cfg", 256'(pad_cfg), 256'(e.cfg));
                chk("func_in", 256'(func_in), 256'(e.fin));
                chk("cfg_ready", {255'd0, cfg_ready}, {255'd0, e.ready});
                chk("busy",      {255'd0, busy},      {255'd0, !e.ready});
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        mux_sel   = '0;
        cfg_in    = '0;
        ovr       = 1'b0;
        tog       = 1'b0;
        model_reset();
        randomize_bg();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        repeat (10) step();
        do_reset();
        repeat (4) step();

        // pad 3 moves to function 2 while pad 5 toggles on function 0
        ovr = 1'b1;
        randomize_bg();
        load_from_model();
        t_sel[3] = 2;
        drive_req();
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (10) step();
        ovr = 1'b0;

        // config-only change
        load_from_model();
        t_cfg[0] = 'h15;
        drive_req();
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (3) step();

        // second set offered while busy must wait for ready
        load_from_model();
        t_sel[7] = 1;
        t_cfg[7] = 9;
        drive_req();
        cfg_valid = 1'b1;
        step();
        t_sel[8] = 3;
        t_cfg[8] = 33;
        drive_req();
        repeat (8) step();
        cfg_valid = 1'b0;
        repeat (8) step();

        // reset during DRAIN discards the request
        load_from_model();
        t_sel[10] = (t_sel[10] + 1) % F;
        t_cfg[10] = 17;
        drive_req();
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (2) step();
        do_reset();
        repeat (5) step();

        for (int i = 0; i < 400; i++) begin
            load_from_model();
            for (int c = 0; c < int'($urandom_range(3, 0)); c++) begin
                t_sel[$urandom_range(N-1, 0)] = int'($urandom_range(F-1, 0));
            end
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(3, 0) == 0) t_cfg[p] = int'($urandom_range(63, 0));
            end
            drive_req();
            cfg_valid = ($urandom_range(3, 0) == 0);
            step();
        end
        cfg_valid = 1'b0;
        repeat (8) step();

        @(negedge clk);
        #2;
        chk("queue_drained", 256'(exp_q.size()), 256'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
